// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: captures register-file operands with same-edge WB bypass, forwards MEM/WB
// results in EX, detects load-use hazards. Optional HAZARD_STATS_EN adds saturating stall/forward counters.
module id_ex_operand_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 12,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              IdValid,
    input  logic [4:0]        IdRs,
    input  logic [4:0]        IdRt,
    input  logic              IdUsesRs,
    input  logic              IdUsesRt,
    input  logic [4:0]        IdDest,
    input  logic              IdRegWrite,
    input  logic              IdMemRead,
    input  logic [DATA_W-1:0] IdImm,
    input  logic [CTRL_W-1:0] IdCtrl,
    input  logic [DATA_W-1:0] ReadData1,
    input  logic [DATA_W-1:0] ReadData2,
    input  logic              Flush,
    input  logic              MemRegWrite,
    input  logic [4:0]        MemDest,
    input  logic [DATA_W-1:0] MemResult,
    input  logic              WbRegWrite,
    input  logic [4:0]        WbDest,
    input  logic [DATA_W-1:0] WbData,
    output logic              Stall,
    output logic              ExValid,
    output logic [4:0]        ExRs,
    output logic [4:0]        ExRt,
    output logic [4:0]        ExDest,
    output logic              ExRegWrite,
    output logic              ExMemRead,
    output logic [DATA_W-1:0] ExImm,
    output logic [CTRL_W-1:0] ExCtrl,
    output logic [DATA_W-1:0] ExOperandA,
    output logic [DATA_W-1:0] ExOperandB,
    output logic [CNT_W-1:0]  StallCount,
    output logic [CNT_W-1:0]  FwdCount
);

    logic              valid_q, valid_d;
    logic [4:0]        rs_q, rt_q, dest_q;
    logic              regwrite_q, regwrite_d;
    logic              memread_q, memread_d;
    logic [DATA_W-1:0] imm_q;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] opa_q, opa_d, opb_q, opb_d;
    logic              fwd_a_mem, fwd_a_wb, fwd_b_mem, fwd_b_wb;

    // Load-use hazard; Flush and reset both suppress it.
    always_comb begin
        Stall = 1'b0;
        if (!rst && valid_q && memread_q && (dest_q != 5'd0) && IdValid && !Flush) begin
            Stall = (IdUsesRs && (IdRs == dest_q)) || (IdUsesRt && (IdRt == dest_q));
        end
    end

    // Capture-side next state: same-edge WB bypass and bubble insertion.
    always_comb begin
        opa_d      = ReadData1;
        opb_d      = ReadData2;
        valid_d    = IdValid;
        regwrite_d = IdRegWrite;
        memread_d  = IdMemRead;
        ctrl_d     = IdCtrl;
        if (WbRegWrite && (WbDest == IdRs) && (IdRs != 5'd0)) opa_d = WbData;
        if (WbRegWrite && (WbDest == IdRt) && (IdRt != 5'd0)) opb_d = WbData;
        if (Flush || Stall) begin
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
            memread_d  = 1'b0;
            ctrl_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            rs_q       <= '0;
            rt_q       <= '0;
            dest_q     <= '0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            imm_q      <= '0;
            ctrl_q     <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
        end else begin
            valid_q    <= valid_d;
            rs_q       <= IdRs;
            rt_q       <= IdRt;
            dest_q     <= IdDest;
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
            imm_q      <= IdImm;
            ctrl_q     <= ctrl_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
        end
    end

    // EX forwarding: $0 pinned to zero, MEM beats WB.
    always_comb begin
        fwd_a_mem  = (rs_q != 5'd0) && MemRegWrite && (MemDest == rs_q);
        fwd_a_wb   = (rs_q != 5'd0) && !fwd_a_mem && WbRegWrite && (WbDest == rs_q);
        fwd_b_mem  = (rt_q != 5'd0) && MemRegWrite && (MemDest == rt_q);
        fwd_b_wb   = (rt_q != 5'd0) && !fwd_b_mem && WbRegWrite && (WbDest == rt_q);
        ExOperandA = opa_q;
        ExOperandB = opb_q;
        if (rs_q == 5'd0)   ExOperandA = '0;
        else if (fwd_a_mem) ExOperandA = MemResult;
        else if (fwd_a_wb)  ExOperandA = WbData;
        if (rt_q == 5'd0)   ExOperandB = '0;
        else if (fwd_b_mem) ExOperandB = MemResult;
        else if (fwd_b_wb)  ExOperandB = WbData;
    end

    assign ExValid    = valid_q;
    assign ExRs       = rs_q;
    assign ExRt       = rt_q;
    assign ExDest     = dest_q;
    assign ExRegWrite = regwrite_q;
    assign ExMemRead  = memread_q;
    assign ExImm      = imm_q;
    assign ExCtrl     = ctrl_q;

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q, fwd_cnt_q;
    logic             fwd_any;

    assign fwd_any = fwd_a_mem || fwd_a_wb || fwd_b_mem || fwd_b_wb;

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            if (Stall && !(&stall_cnt_q))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (valid_q && fwd_any && !(&fwd_cnt_q))
                fwd_cnt_q <= fwd_cnt_q + CNT_W'(1);
        end
    end

    assign StallCount = stall_cnt_q;
    assign FwdCount   = fwd_cnt_q;
`else
    assign StallCount = '0;
    assign FwdCount   = '0;
`endif

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed self-checking bench for id_ex_operand_stage; counter expectations follow HAZARD_STATS_EN.
module tb_id_ex_operand_stage;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CTRL_W = 12;
    localparam int unsigned CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              IdValid, IdUsesRs, IdUsesRt, IdRegWrite, IdMemRead;
    logic [4:0]        IdRs, IdRt, IdDest;
    logic [DATA_W-1:0] IdImm, ReadData1, ReadData2;
    logic [CTRL_W-1:0] IdCtrl;
    logic              Flush, MemRegWrite, WbRegWrite;
    logic [4:0]        MemDest, WbDest;
    logic [DATA_W-1:0] MemResult, WbData;
    logic              Stall, ExValid, ExRegWrite, ExMemRead;
    logic [4:0]        ExRs, ExRt, ExDest;
    logic [DATA_W-1:0] ExImm, ExOperandA, ExOperandB;
    logic [CTRL_W-1:0] ExCtrl;
    logic [CNT_W-1:0]  StallCount, FwdCount;

    int checks   = 0;
    int failures = 0;

    id_ex_operand_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .IdValid(IdValid), .IdRs(IdRs), .IdRt(IdRt), .IdUsesRs(IdUsesRs), .IdUsesRt(IdUsesRt),
        .IdDest(IdDest), .IdRegWrite(IdRegWrite), .IdMemRead(IdMemRead), .IdImm(IdImm),
        .IdCtrl(IdCtrl), .ReadData1(ReadData1), .ReadData2(ReadData2), .Flush(Flush),
        .MemRegWrite(MemRegWrite), .MemDest(MemDest), .MemResult(MemResult),
        .WbRegWrite(WbRegWrite), .WbDest(WbDest), .WbData(WbData),
        .Stall(Stall), .ExValid(ExValid), .ExRs(ExRs), .ExRt(ExRt), .ExDest(ExDest),
        .ExRegWrite(ExRegWrite), .ExMemRead(ExMemRead), .ExImm(ExImm), .ExCtrl(ExCtrl),
        .ExOperandA(ExOperandA), .ExOperandB(ExOperandB),
        .StallCount(StallCount), .FwdCount(FwdCount)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        IdValid = 0; IdRs = 0; IdRt = 0; IdUsesRs = 0; IdUsesRt = 0; IdDest = 0;
        IdRegWrite = 0; IdMemRead = 0; IdImm = 0; IdCtrl = 0; ReadData1 = 0; ReadData2 = 0;
        Flush = 0; MemRegWrite = 0; MemDest = 0; MemResult = 0;
        WbRegWrite = 0; WbDest = 0; WbData = 0;
    endtask

    task automatic drive_id(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                            input logic urt, input logic [4:0] dest, input logic rw,
                            input logic mr, input logic [31:0] imm, input logic [11:0] ctrl,
                            input logic [31:0] rd1, input logic [31:0] rd2);
        IdValid = 1; IdRs = rs; IdRt = rt; IdUsesRs = urs; IdUsesRt = urt; IdDest = dest;
        IdRegWrite = rw; IdMemRead = mr; IdImm = imm; IdCtrl = ctrl;
        ReadData1 = rd1; ReadData2 = rd2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic test_reset();
        int exp_cnt;
        exp_cnt = 0;
        @(negedge clk);
        clear_inputs();
        rst = 1;
        drive_id(5'd3, 5'd4, 1, 1, 5'd7, 1, 1, 32'h55, 12'hFFF, 32'h11, 32'h22);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", Stall); end
        checks++; if (ExValid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", ExValid); end
        checks++; if (ExDest !== 5'd0 || ExRs !== 5'd0 || ExRt !== 5'd0) begin failures++; $display("FAIL reset_regs got=%h/%h/%h exp=0", ExDest, ExRs, ExRt); end
        checks++; if (ExImm !== '0 || ExCtrl !== '0) begin failures++; $display("FAIL reset_imm_ctrl got=%h/%h exp=0", ExImm, ExCtrl); end
        checks++; if (ExRegWrite !== 1'b0 || ExMemRead !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", ExRegWrite, ExMemRead); end
        checks++; if (ExOperandA !== '0 || ExOperandB !== '0) begin failures++; $display("FAIL reset_ops got=%h/%h exp=0", ExOperandA, ExOperandB); end
        checks++; if (StallCount !== CNT_W'(exp_cnt) || FwdCount !== CNT_W'(exp_cnt)) begin failures++; $display("FAIL reset_counters got=%0d/%0d exp=0", StallCount, FwdCount); end
        rst = 0;
    endtask

    task automatic test_load_use();
        int exp_stall, exp_fwd;
`ifdef HAZARD_STATS_EN
        exp_stall = 1; exp_fwd = 1;
`else
        exp_stall = 0; exp_fwd = 0;
`endif
        do_reset();
        @(negedge clk);
        drive_id(5'd1, 5'd0, 1, 0, 5'd8, 1, 1, 32'd4, 12'h0A5, 32'd100, 32'd0);
        @(posedge clk); #1;
        checks++; if (ExValid !== 1'b1 || ExMemRead !== 1'b1 || ExDest !== 5'd8) begin failures++; $display("FAIL lu_load_capture got=%b%b/%0d exp=11/8", ExValid, ExMemRead, ExDest); end
        checks++; if (ExImm !== 32'd4 || ExCtrl !== 12'h0A5 || ExOperandA !== 32'd100) begin failures++; $display("FAIL lu_load_fields got=%h/%h/%h exp=4/0a5/64", ExImm, ExCtrl, ExOperandA); end
        @(negedge clk);
        drive_id(5'd8, 5'd2, 1, 1, 5'd10, 1, 0, 32'd0, 12'h011, 32'd0, 32'd7);
        #1;
        checks++; if (Stall !== 1'b1) begin failures++; $display("FAIL lu_stall got=%b exp=1", Stall); end
        @(posedge clk); #1;
        checks++; if (ExValid !== 1'b0 || ExCtrl !== '0 || ExRegWrite !== 1'b0) begin failures++; $display("FAIL lu_bubble got=%b/%h/%b exp=0/000/0", ExValid, ExCtrl, ExRegWrite); end
        checks++; if (StallCount !== CNT_W'(exp_stall)) begin failures++; $display("FAIL lu_stall_count got=%0d exp=%0d", StallCount, exp_stall); end
        @(negedge clk);
        MemRegWrite = 1; MemDest = 5'd8; MemResult = 32'h64;
        #1;
        checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL lu_stall_once got=%b exp=0", Stall); end
        @(posedge clk); #1;
        checks++; if (ExValid !== 1'b1 || ExRs !== 5'd8 || ExCtrl !== 12'h011) begin failures++; $display("FAIL lu_add_capture got=%b/%0d/%h exp=1/8/011", ExValid, ExRs, ExCtrl); end
        @(negedge clk);
        MemRegWrite = 0; MemDest = 0; WbRegWrite = 1; WbDest = 5'd8; WbData = 32'hD00D;
        IdValid = 0;
        #1;
        checks++; if (ExOperandA !== 32'hD00D || ExOperandB !== 32'd7) begin failures++; $display("FAIL lu_wb_forward got=%h/%h exp=d00d/7", ExOperandA, ExOperandB); end
        @(posedge clk); #1;
        checks++; if (FwdCount !== CNT_W'(exp_fwd)) begin failures++; $display("FAIL lu_fwd_count got=%0d exp=%0d", FwdCount, exp_fwd); end
    endtask

    task automatic test_hazard_cases();
        do_reset();
        @(negedge clk);
        drive_id(5'd1, 5'd0, 1, 0, 5'd8, 1, 1, 32'd0, 12'h001, 32'd0, 32'd0);
        @(posedge clk);
        @(negedge clk);
        drive_id(5'd3, 5'd8, 1, 1, 5'd9, 1, 0, 32'd0, 12'h002, 32'd0, 32'd0);
        #1;
        checks++; if (Stall !== 1'b1) begin failures++; $display("FAIL hz_rt_match got=%b exp=1", Stall); end
        IdUsesRt = 0; #1;
        checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL hz_rt_unused got=%b exp=0", Stall); end
        IdUsesRt = 1; IdValid = 0; #1;
        checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL hz_id_invalid got=%b exp=0", Stall); end
        // A load to $0 never stalls.
        do_reset();
        @(negedge clk);
        drive_id(5'd1, 5'd0, 1, 0, 5'd0, 1, 1, 32'd0, 12'h001, 32'd0, 32'd0);
        @(posedge clk);
        @(negedge clk);
        drive_id(5'd0, 5'd0, 1, 1, 5'd9, 1, 0, 32'd0, 12'h002, 32'd0, 32'd0);
        #1;
        checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL hz_load_r0 got=%b exp=0", Stall); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        @(negedge clk);
        drive_id(5'd9, 5'd3, 1, 1, 5'd12, 1, 0, 32'd0, 12'h003, 32'h1111, 32'h2222);
        @(posedge clk);
        @(negedge clk);
        IdValid = 0;
        MemRegWrite = 1; MemDest = 5'd9; MemResult = 32'h1234;
        WbRegWrite = 1; WbDest = 5'd9; WbData = 32'hBEEF;
        #1;
        checks++; if (ExOperandA !== 32'h1234 || ExOperandB !== 32'h2222) begin failures++; $display("FAIL b2b_mem_priority got=%h/%h exp=1234/2222", ExOperandA, ExOperandB); end
        MemRegWrite = 0; #1;
        checks++; if (ExOperandA !== 32'hBEEF) begin failures++; $display("FAIL b2b_wb got=%h exp=beef", ExOperandA); end
        WbRegWrite = 0; MemRegWrite = 1; MemDest = 5'd3; #1;
        checks++; if (ExOperandA !== 32'h1111 || ExOperandB !== 32'h1234) begin failures++; $display("FAIL b2b_rt_mem got=%h/%h exp=1111/1234", ExOperandA, ExOperandB); end
    endtask

    task automatic test_same_edge_wb();
        do_reset();
        @(negedge clk);
        drive_id(5'd5, 5'd6, 1, 1, 5'd7, 1, 0, 32'd0, 12'h004, 32'd0, 32'h66);
        WbRegWrite = 1; WbDest = 5'd5; WbData = 32'hCAFE;
        @(posedge clk);
        @(negedge clk);
        clear_inputs();
        #1;
        checks++; if (ExOperandA !== 32'hCAFE || ExOperandB !== 32'h66) begin failures++; $display("FAIL same_edge_bypass got=%h/%h exp=cafe/66", ExOperandA, ExOperandB); end
    endtask

    task automatic test_zero_reg();
        do_reset();
        @(negedge clk);
        drive_id(5'd0, 5'd0, 1, 1, 5'd4, 1, 0, 32'd0, 12'h005, 32'd0, 32'd0);
        @(posedge clk);
        @(negedge clk);
        IdValid = 0;
        MemRegWrite = 1; MemDest = 5'd0; MemResult = 32'hFFFF_FFFF;
        WbRegWrite = 1; WbDest = 5'd0; WbData = 32'hABCD;
        #1;
        checks++; if (ExOperandA !== 32'd0 || ExOperandB !== 32'd0) begin failures++; $display("FAIL zero_reg got=%h/%h exp=0/0", ExOperandA, ExOperandB); end
        @(posedge clk); #1;
        checks++; if (FwdCount !== CNT_W'(0)) begin failures++; $display("FAIL zero_reg_fwd_count got=%0d exp=0", FwdCount); end
    endtask

    task automatic test_flush();
        do_reset();
        @(negedge clk);
        drive_id(5'd1, 5'd0, 1, 0, 5'd8, 1, 1, 32'd0, 12'h006, 32'd0, 32'd0);
        @(posedge clk);
        @(negedge clk);
        drive_id(5'd8, 5'd0, 1, 0, 5'd10, 1, 0, 32'd0, 12'h007, 32'd0, 32'd0);
        Flush = 1;
        #1;
        checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL flush_stall got=%b exp=0", Stall); end
        @(posedge clk); #1;
        checks++; if (ExValid !== 1'b0 || ExCtrl !== '0 || ExMemRead !== 1'b0 || ExRegWrite !== 1'b0) begin failures++; $display("FAIL flush_bubble got=%b/%h/%b%b exp=0/000/00", ExValid, ExCtrl, ExMemRead, ExRegWrite); end
        checks++; if (StallCount !== CNT_W'(0)) begin failures++; $display("FAIL flush_stall_count got=%0d exp=0", StallCount); end
        Flush = 0;
    endtask

    task automatic test_rst_mid_stall();
        do_reset();
        @(negedge clk);
        drive_id(5'd1, 5'd0, 1, 0, 5'd8, 1, 1, 32'd0, 12'h008, 32'd0, 32'd0);
        @(posedge clk);
        @(negedge clk);
        drive_id(5'd8, 5'd0, 1, 0, 5'd10, 1, 0, 32'd0, 12'h009, 32'd0, 32'd0);
        #1;
        checks++; if (Stall !== 1'b1) begin failures++; $display("FAIL rst_mid_pre got=%b exp=1", Stall); end
        rst = 1; #1;
        checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL rst_mid_stall got=%b exp=0", Stall); end
        @(posedge clk); #1;
        rst = 0;
        checks++; if (ExValid !== 1'b0 || ExCtrl !== '0 || StallCount !== CNT_W'(0)) begin failures++; $display("FAIL rst_mid_bubble got=%b/%h/%0d exp=0/000/0", ExValid, ExCtrl, StallCount); end
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        test_reset();
        test_load_use();
        test_hazard_cases();
        test_back_to_back();
        test_same_edge_wb();
        test_zero_reg();
        test_flush();
        test_rst_mid_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
